// File: rtl/dmem_dma_engine.sv
// dmem_dma_engine
// Copies a block of words, or fills a region with a constant. It drives the
// data memory's single-port interface and keeps a running sum of the words
// it writes.
//
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   start/op        one-cycle command strobe (sampled in IDLE only);
//                   op 0 = copy, 1 = fill
//   src/dst/len     source base, destination base, word count (0..64, clamped)
//   fill_val        fill constant
//   mem_A/WE/WD     memory address, write enable and write data
//   mem_RD          combinational read data for mem_A
//   busy            high while the engine owns the memory port (RD/WR)
//   done            one-cycle completion pulse
//   checksum        mod-2^32 sum of every word written by the last command
module dmem_dma_engine #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    input  logic [DW-1:0] fill_val,
    output logic [AW-1:0] mem_A,
    output logic          mem_WE,
    output logic [DW-1:0] mem_WD,
    input  logic [DW-1:0] mem_RD,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum
);

    localparam logic [AW:0] MAX_LEN = (AW+1)'(1 << AW);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t        state, state_nxt;
    logic          op_r;
    logic [AW-1:0] src_r, dst_r;
    logic [AW:0]   len_r, idx;
    logic [DW-1:0] fill_r, buf_r;
    logic [AW:0]   len_clamp;
    logic          last;

    assign len_clamp = (len > MAX_LEN) ? MAX_LEN : len;
    assign last      = ((idx + 1'b1) == len_r);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len_clamp == '0) state_nxt = S_DONE;
                    else if (op)         state_nxt = S_WR;
                    else                 state_nxt = S_RD;
                end
            end
            S_RD:    state_nxt = S_WR;
            S_WR: begin
                if (last)       state_nxt = S_DONE;
                else if (op_r)  state_nxt = S_WR;
                else            state_nxt = S_RD;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; addresses wrap naturally in AW bits
    always_comb begin
        mem_A  = '0;
        mem_WE = 1'b0;
        mem_WD = '0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state)
            S_RD: begin
                mem_A = src_r + idx[AW-1:0];
                busy  = 1'b1;
            end
            S_WR: begin
                mem_A  = dst_r + idx[AW-1:0];
                // Suppress the write on the reset edge so an abort never
                // commits the word in flight.
                mem_WE = ~RST;
                mem_WD = op_r ? fill_r : buf_r;
                busy   = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Command operands, word index, read buffer and checksum
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_r     <= 1'b0;
            src_r    <= '0;
            dst_r    <= '0;
            len_r    <= '0;
            fill_r   <= '0;
            buf_r    <= '0;
            idx      <= '0;
            checksum <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        src_r    <= src;
                        dst_r    <= dst;
                        len_r    <= len_clamp;
                        fill_r   <= fill_val;
                        idx      <= '0;
                        checksum <= '0;
                    end
                end
                S_RD: buf_r <= mem_RD;
                S_WR: begin
                    checksum <= checksum + mem_WD;
                    idx      <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_dma_engine.sv
// Self-checking bench for dmem_dma_engine: a behavioural memory, a reference
// model of copy/fill on an array, directed cases and randomized commands.
module tb_dmem_dma_engine;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start, op;
    logic [5:0]  src, dst;
    logic [6:0]  len;
    logic [31:0] fill_val;
    logic [5:0]  mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD, mem_RD;
    logic        busy, done;
    logic [31:0] checksum;

    always #5 CLK = ~CLK;

    dmem_dma_engine #(.AW(6), .DW(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op(op), .src(src), .dst(dst),
        .len(len), .fill_val(fill_val), .mem_A(mem_A), .mem_WE(mem_WE),
        .mem_WD(mem_WD), .mem_RD(mem_RD), .busy(busy), .done(done),
        .checksum(checksum)
    );

    // Memory and bus monitor. This block is the only writer of mem and the
    // counters; the stimulus side only reads them or requests a preload.
    logic [31:0] mem [64];
    logic [31:0] img [64];
    int          load_seq = 0, load_seen = 0;
    int          wr_total = 0;
    int          wcnt [64];
    int          rdq [$];

    assign mem_RD = mem[mem_A];

    initial for (int k = 0; k < 64; k++) wcnt[k] = 0;

    always @(posedge CLK) begin
        if (load_seq != load_seen) begin
            for (int k = 0; k < 64; k++) mem[k] = img[k];
            load_seen = load_seq;
        end else begin
            if (mem_WE) begin
                mem[mem_A] = mem_WD;
                wr_total++;
                wcnt[mem_A]++;
            end
            if (busy && !mem_WE) rdq.push_back(int'(mem_A));
        end
    end

    int          errs = 0, nchk = 0;
    logic [31:0] exp_mem [64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Preload memory from img; the model starts from the same image
    task automatic preload();
        for (int k = 0; k < 64; k++) exp_mem[k] = img[k];
        load_seq++;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Issue one command and check it against the reference model.
    // glitch > 0 pulses start with different operands in that cycle.
    task automatic run(input bit o, input logic [5:0] s, input logic [5:0] d,
                       input logic [6:0] l, input logic [31:0] fv, input int glitch);
        int          n, exp_cyc, cyc, base_wr, base_rd, mism;
        int          base_w [64];
        logic [31:0] cs, v, cs_done;
        bit          got;
        n = (l > 7'd64) ? 64 : int'(l);
        exp_cyc = (n == 0) ? 1 : (o ? n + 1 : 2 * n + 1);
        cs = 0;
        for (int k = 0; k < n; k++) begin
            v = o ? fv : exp_mem[(int'(s) + k) % 64];
            exp_mem[(int'(d) + k) % 64] = v;
            cs += v;
        end
        base_wr = wr_total;
        base_rd = rdq.size();
        for (int k = 0; k < 64; k++) base_w[k] = wcnt[k];

        @(negedge CLK);
        start = 1'b1; op = o; src = s; dst = d; len = l; fill_val = fv;
        cyc = 0; got = 0; cs_done = 0;
        while (!got && cyc < 300) begin
            @(negedge CLK);
            cyc++;
            start = 1'b0;
            if (cyc == glitch) begin
                start = 1'b1; op = ~o; src = 6'($urandom); dst = 6'($urandom);
                len = 7'($urandom_range(1, 64)); fill_val = $urandom;
            end
            if (done) begin
                got = 1;
                cs_done = checksum;
            end
        end
        chk("done_cycle", 32'(cyc), 32'(exp_cyc));
        chk("checksum", cs_done, cs);
        @(negedge CLK);
        start = 1'b0;
        chk("idle_flags", {30'd0, busy, done}, 32'd0);
        chk("checksum_hold", checksum, cs);
        chk("write_count", 32'(wr_total - base_wr), 32'(n));
        mism = 0;
        for (int k = 0; k < 64; k++)
            if ((wcnt[k] - base_w[k]) != ((((k - int'(d) + 64) % 64) < n) ? 1 : 0)) mism++;
        chk("write_coverage", 32'(mism), 32'd0);
        mism = 0;
        if (rdq.size() - base_rd != (o ? 0 : n)) mism++;
        else if (!o)
            for (int k = 0; k < n; k++)
                if (rdq[base_rd + k] != (int'(s) + k) % 64) mism++;
        chk("read_order", 32'(mism), 32'd0);
        mism = 0;
        for (int k = 0; k < 64; k++) if (mem[k] !== exp_mem[k]) mism++;
        chk("mem_image", 32'(mism), 32'd0);
    endtask

    initial begin
        int          mism;
        logic [5:0]  rd;
        logic [31:0] rv;
        RST = 1'b1; start = 1'b0; op = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
        for (int k = 0; k < 64; k++) img[k] = $urandom;
        preload();
        @(negedge CLK);
        chk("rst_outs", {mem_A, mem_WE, busy, done}, 32'd0);
        chk("rst_wd", mem_WD, 32'd0);
        chk("rst_cs", checksum, 32'd0);
        RST = 1'b0;

        // Fill 20..23 with a constant
        run(1'b1, 6'd20, 6'd20, 7'd4, 32'hDEADBEEF, 0);
        chk("fill_cs_const", checksum, 32'h7AB6FBBC);

        // Block copy of a known ramp
        for (int k = 0; k < 64; k++) img[k] = (k < 10) ? 32'(10 * (k + 1)) : $urandom;
        preload();
        run(1'b0, 6'd0, 6'd32, 7'd10, 32'h0, 0);
        chk("copy_cs_const", checksum, 32'd550);
        mism = 0;
        for (int k = 0; k < 10; k++) begin
            if (mem[32 + k] !== 32'(10 * (k + 1))) mism++;
            if (mem[k] !== 32'(10 * (k + 1))) mism++;
        end
        chk("copy_ramp", 32'(mism), 32'd0);

        // Source wraps past 63
        run(1'b0, 6'd62, 6'd1, 7'd4, 32'h0, 0);

        // Overlapping copy smears mem[0]
        img[0] = 32'd10;
        for (int k = 1; k < 64; k++) img[k] = $urandom;
        preload();
        run(1'b0, 6'd0, 6'd1, 7'd3, 32'h0, 0);
        chk("smear", {mem[1] ^ 32'd10} | {mem[2] ^ 32'd10} | {mem[3] ^ 32'd10}, 32'd0);

        // Zero length and oversize length
        run(1'b0, 6'd5, 6'd9, 7'd0, 32'h0, 0);
        chk("len0_cs", checksum, 32'd0);
        run(1'b1, 6'd0, 6'd50, 7'd100, 32'h1234_5678, 0);

        // start during busy and during DONE is ignored
        run(1'b1, 6'd0, 6'd10, 7'd6, 32'hCAFE_F00D, 3);
        run(1'b0, 6'd40, 6'd60, 7'd5, 32'h0, 4);
        run(1'b1, 6'd0, 6'd30, 7'd3, 32'h5555_AAAA, 4);
        run(1'b0, 6'd7, 6'd20, 7'd2, 32'h0, 5);

        // Reset during the third write of an 8-word fill
        rv = $urandom;
        mism = wr_total;
        @(negedge CLK);
        start = 1'b1; op = 1'b1; dst = 6'd40; len = 7'd8; fill_val = rv;
        @(negedge CLK); start = 1'b0;
        @(negedge CLK);
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        chk("abort_writes", 32'(wr_total - mism), 32'd2);
        chk("abort_outs", {mem_A, mem_WE, busy, done}, 32'd0);
        chk("abort_wd_cs", mem_WD | checksum, 32'd0);
        exp_mem[40] = rv; exp_mem[41] = rv;
        mism = 0;
        for (int k = 0; k < 64; k++) if (mem[k] !== exp_mem[k]) mism++;
        chk("abort_mem", 32'(mism), 32'd0);
        run(1'b1, 6'd0, 6'd40, 7'd8, 32'h0F0F_0F0F, 0);

        // Randomized commands
        for (int t = 0; t < 24; t++) begin
            rd = 6'($urandom);
            run(1'($urandom), 6'($urandom), rd, 7'($urandom_range(0, 100)), $urandom,
                int'($urandom_range(0, 12)));
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
